// File: rtl/branch_predictor.sv
// BTB plus 2-bit saturating counters: zero-cycle lookup on PCF, update on the edge after BranchE.
// No backpressure; resolution outputs are combinational and statistics saturate at 16'hFFFF.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int INDEX_W = $clog2(ENTRIES),
  parameter int TAG_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic        Predict_branchF,
  output logic [31:0] PredTargetF,
  input  logic        BranchE,
  input  logic [31:0] PCE,
  input  logic [31:0] PCTargetE,
  input  logic        TakenE,
  input  logic        Predict_branchE,
  output logic        MispredictE,
  output logic [31:0] RedirectPCE,
  output logic [15:0] BranchCount,
  output logic [15:0] MispredCount
);

  logic               valid_q  [ENTRIES];
  logic               valid_d  [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];
  logic [15:0]        branch_cnt_q, branch_cnt_d;
  logic [15:0]        mispred_cnt_q, mispred_cnt_d;

  logic [INDEX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0]   f_tag, e_tag;
  logic               f_hit, e_hit;

  assign f_idx = PCF[INDEX_W+1:2];
  assign f_tag = PCF[INDEX_W+2 +: TAG_W];
  assign e_idx = PCE[INDEX_W+1:2];
  assign e_tag = PCE[INDEX_W+2 +: TAG_W];

  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

  // Lookup reads the registered tables only, so a same-cycle update is not bypassed.
  assign Predict_branchF = f_hit && ctr_q[f_idx][1];
  assign PredTargetF     = Predict_branchF ? target_q[f_idx] : PCF + 32'd4;

  assign MispredictE  = BranchE && (TakenE ^ Predict_branchE);
  assign RedirectPCE  = TakenE ? PCTargetE : PCE + 32'd4;
  assign BranchCount  = branch_cnt_q;
  assign MispredCount = mispred_cnt_q;

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (BranchE) begin
      if (e_hit) begin
        if (TakenE) begin
          ctr_d[e_idx]    = (ctr_q[e_idx] == 2'b11) ? 2'b11 : ctr_q[e_idx] + 2'd1;
          target_d[e_idx] = PCTargetE;
        end else begin
          ctr_d[e_idx]    = (ctr_q[e_idx] == 2'b00) ? 2'b00 : ctr_q[e_idx] - 2'd1;
        end
      end else if (TakenE) begin
        // Allocate as weakly taken so a single not-taken outcome flips the prediction.
        valid_d[e_idx]  = 1'b1;
        tag_d[e_idx]    = e_tag;
        target_d[e_idx] = PCTargetE;
        ctr_d[e_idx]    = 2'b10;
      end
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (BranchE && (branch_cnt_q != 16'hFFFF)) branch_cnt_d = branch_cnt_q + 16'd1;
    if (MispredictE && (mispred_cnt_q != 16'hFFFF)) mispred_cnt_d = mispred_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      target_q      <= target_d;
      ctr_q         <= ctr_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with a table-level reference model checked every negedge.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] PCF;
  logic        Predict_branchF;
  logic [31:0] PredTargetF;
  logic        BranchE;
  logic [31:0] PCE;
  logic [31:0] PCTargetE;
  logic        TakenE;
  logic        Predict_branchE;
  logic        MispredictE;
  logic [31:0] RedirectPCE;
  logic [15:0] BranchCount;
  logic [15:0] MispredCount;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 0;

  branch_predictor dut (
    .clk(clk), .rst(rst), .PCF(PCF),
    .Predict_branchF(Predict_branchF), .PredTargetF(PredTargetF),
    .BranchE(BranchE), .PCE(PCE), .PCTargetE(PCTargetE),
    .TakenE(TakenE), .Predict_branchE(Predict_branchE),
    .MispredictE(MispredictE), .RedirectPCE(RedirectPCE),
    .BranchCount(BranchCount), .MispredCount(MispredCount)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain integer tables indexed by word address modulo 16.
  bit          m_valid  [16];
  int          m_tag    [16];
  logic [31:0] m_target [16];
  int          m_ctr    [16];
  int          m_bc, m_mc;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc / 64) % 256);
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    int i;
    i = idx_of(pc);
    return m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 0;
        m_ctr[i]   = 1;
      end
      m_bc = 0;
      m_mc = 0;
    end else if (BranchE) begin
      int i;
      bit hit;
      i   = idx_of(PCE);
      hit = m_valid[i] && (m_tag[i] == tag_of(PCE));
      if (hit && TakenE) begin
        if (m_ctr[i] < 3) m_ctr[i] = m_ctr[i] + 1;
        m_target[i] = PCTargetE;
      end else if (hit) begin
        if (m_ctr[i] > 0) m_ctr[i] = m_ctr[i] - 1;
      end else if (TakenE) begin
        m_valid[i]  = 1;
        m_tag[i]    = tag_of(PCE);
        m_target[i] = PCTargetE;
        m_ctr[i]    = 2;
      end
      if (m_bc < 65535) m_bc = m_bc + 1;
      if ((TakenE != Predict_branchE) && m_mc < 65535) m_mc = m_mc + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      bit p;
      p = m_pred(PCF);
      chk("m_pred", 32'(Predict_branchF), 32'(p));
      chk("m_target", PredTargetF, p ? m_target[idx_of(PCF)] : PCF + 32'd4);
      chk("m_mispred", 32'(MispredictE), 32'(BranchE && (TakenE != Predict_branchE)));
      if (BranchE) chk("m_redirect", RedirectPCE, TakenE ? PCTargetE : PCE + 32'd4);
      chk("m_bcount", 32'(BranchCount), 32'(m_bc));
      chk("m_mcount", 32'(MispredCount), 32'(m_mc));
    end
  end

  task automatic step(input logic be, input logic [31:0] pce, input logic [31:0] tgt,
                      input logic tk, input logic pr, input logic [31:0] pcf);
    @(posedge clk);
    #2;
    BranchE = be; PCE = pce; PCTargetE = tgt; TakenE = tk; Predict_branchE = pr; PCF = pcf;
  endtask

  task automatic probe;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1; PCF = 32'h40; BranchE = 0; PCE = 0; PCTargetE = 0; TakenE = 0; Predict_branchE = 0;
    #1 rst = 0;
    cmp_en = 1;
    probe();
    chk("reset_pred", 32'(Predict_branchF), 32'h0);
    chk("reset_target", PredTargetF, 32'h44);
    chk("reset_bcount", 32'(BranchCount), 32'h0);
    chk("reset_mcount", 32'(MispredCount), 32'h0);
    @(posedge clk); #2 rst = 1;

    // Allocation; lookup in the same cycle still sees the old (empty) entry.
    step(1, 32'h40, 32'h100, 1, 0, 32'h40);
    probe();
    chk("alloc_mispred", 32'(MispredictE), 32'h1);
    chk("alloc_redirect", RedirectPCE, 32'h100);
    chk("same_cycle_pred", 32'(Predict_branchF), 32'h0);
    step(0, 32'h0, 32'h0, 0, 0, 32'h40);
    probe();
    chk("alloc_pred", 32'(Predict_branchF), 32'h1);
    chk("alloc_target", PredTargetF, 32'h100);
    chk("alloc_bcount", 32'(BranchCount), 32'h1);
    chk("alloc_mcount", 32'(MispredCount), 32'h1);

    // Two not-taken resolutions: ctr 2 -> 1 -> 0.
    step(1, 32'h40, 32'h100, 0, 1, 32'h40);
    probe();
    chk("nt1_mispred", 32'(MispredictE), 32'h1);
    chk("nt1_redirect", RedirectPCE, 32'h44);
    step(1, 32'h40, 32'h100, 0, 0, 32'h40);
    probe();
    chk("nt2_mispred", 32'(MispredictE), 32'h0);
    chk("nt2_pred", 32'(Predict_branchF), 32'h0);
    chk("nt2_target", PredTargetF, 32'h44);

    // Saturate up to strong taken, then one not-taken keeps the prediction taken.
    step(1, 32'h40, 32'h100, 1, 0, 32'h40);
    step(1, 32'h40, 32'h100, 1, 0, 32'h40);
    step(1, 32'h40, 32'h100, 1, 1, 32'h40);
    step(1, 32'h40, 32'h100, 1, 1, 32'h40);
    step(1, 32'h40, 32'h100, 0, 1, 32'h40);
    step(0, 32'h0, 32'h0, 0, 0, 32'h40);
    probe();
    chk("hyst_pred", 32'(Predict_branchF), 32'h1);
    chk("hyst_target", PredTargetF, 32'h100);

    // PCs differing only above the tag bits alias to the same entry.
    step(0, 32'h0, 32'h0, 0, 0, 32'h4040);
    probe();
    chk("wrap_alias_pred", 32'(Predict_branchF), 32'h1);
    chk("wrap_alias_target", PredTargetF, 32'h100);

    // Tag conflict on index 0 replaces the entry.
    step(1, 32'h80, 32'h200, 1, 0, 32'h40);
    step(0, 32'h0, 32'h0, 0, 0, 32'h40);
    probe();
    chk("conflict_old_pred", 32'(Predict_branchF), 32'h0);
    chk("conflict_old_target", PredTargetF, 32'h44);
    step(0, 32'h0, 32'h0, 0, 0, 32'h80);
    probe();
    chk("conflict_new_target", PredTargetF, 32'h200);

    // PC+4 wraps modulo 2^32.
    step(1, 32'hFFFFFFFC, 32'h0, 0, 0, 32'hFFFFFFFC);
    probe();
    chk("wrap_pcf4", PredTargetF, 32'h0);
    chk("wrap_redirect", RedirectPCE, 32'h0);

    // Reset asserted while an update is pending: outputs clear at once, update lost.
    step(1, 32'h80, 32'h300, 0, 1, 32'h80);
    #2 rst = 0;
    #1;
    chk("arst_pred", 32'(Predict_branchF), 32'h0);
    chk("arst_target", PredTargetF, 32'h84);
    chk("arst_bcount", 32'(BranchCount), 32'h0);
    @(posedge clk); #2 rst = 1; BranchE = 0;
    probe();
    chk("arst_lost_pred", 32'(Predict_branchF), 32'h0);
    chk("arst_lost_bcount", 32'(BranchCount), 32'h0);

    // Counter saturation.
    step(1, 32'h40, 32'h100, 1, 0, 32'h40);
    repeat (70000) @(posedge clk);
    #2 BranchE = 0;
    probe();
    chk("sat_bcount", 32'(BranchCount), 32'hFFFF);
    chk("sat_mcount", 32'(MispredCount), 32'hFFFF);

    cmp_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
